// File: rtl/tc_rescale_pkg.sv
// Shared constants and the saturation helper for the product rescale block.
package tc_rescale_pkg;

    localparam int PROD_W = 31;
    localparam int SHIFT  = 14;
    localparam int OUT_W  = 14;

    localparam logic [PROD_W:0] RND_C = (PROD_W + 1)'(1) << (SHIFT - 1);

    // Clips a signed value to a signed range of 'width' bits; returns {ovf, result}.
    function automatic logic [OUT_W:0] sat_s(input logic signed [PROD_W:0] value,
                                             input int width);
        logic signed [PROD_W:0] hi;
        logic signed [PROD_W:0] lo;
        hi = $signed(((PROD_W + 1)'(1) << (width - 1)) - (PROD_W + 1)'(1));
        lo = ~hi;
        if (value > hi) begin
            return {1'b1, hi[OUT_W-1:0]};
        end else if (value < lo) begin
            return {1'b1, lo[OUT_W-1:0]};
        end
        return {1'b0, value[OUT_W-1:0]};
    endfunction

endpackage

// File: rtl/tc_rescale_fifo.sv
// First-word-fall-through FIFO with an occupancy count; head is zero while empty.
module tc_rescale_fifo
    import tc_rescale_pkg::*;
#(
    parameter int W     = 15,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_sys,
    input  logic          rst_b,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;

    assign rd_valid = (count != '0);
    assign pop      = rd_en & rd_valid;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Explicit wrap so non-power-of-two depths also work.
    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tc_product_rescale.sv
// Round, shift and saturate the multiplier product; credit-managed FWFT output stream.
// Optional saturation counter and its ports are enabled by TC_RESCALE_SAT_CNT_EN.
module tc_product_rescale
    import tc_rescale_pkg::*;
#(
    parameter int PROD_W     = tc_rescale_pkg::PROD_W,
    parameter int SHIFT      = tc_rescale_pkg::SHIFT,
    parameter int OUT_W      = tc_rescale_pkg::OUT_W,
    parameter int FIFO_DEPTH = 4
`ifdef TC_RESCALE_SAT_CNT_EN
    , parameter int CNT_W    = 16
`endif
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PROD_W-1:0] s_prod,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_ovf
`ifdef TC_RESCALE_SAT_CNT_EN
    , input  logic             clr_cnt,
    output logic [CNT_W-1:0]  sat_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                     run;
    logic                     v1;
    logic signed [PROD_W:0]   r1;
    logic                     v2;
    logic [OUT_W-1:0]         d2;
    logic                     o2;
    logic signed [PROD_W:0]   q_c;
    logic [OUT_W:0]           sat_v;
    logic [OUT_W:0]           head;
    logic [CW-1:0]            fifo_cnt;
    logic [CW:0]              inflight;

    // Every word already accepted holds a FIFO slot, so writes can never overflow.
    assign inflight = (CW + 1)'(fifo_cnt) + (CW + 1)'(v1) + (CW + 1)'(v2);
    assign s_ready  = run && (inflight < (CW + 1)'(FIFO_DEPTH));

    assign q_c   = r1 >>> SHIFT;
    assign sat_v = sat_s(q_c, OUT_W);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            run <= 1'b0;
            v1  <= 1'b0;
            r1  <= '0;
            v2  <= 1'b0;
            d2  <= '0;
            o2  <= 1'b0;
        end else begin
            run <= 1'b1;
            v1  <= s_valid & s_ready;
            if (s_valid & s_ready) begin
                r1 <= $signed({s_prod[PROD_W-1], s_prod}) + $signed(RND_C);
            end
            v2 <= v1;
            if (v1) begin
                d2 <= sat_v[OUT_W-1:0];
                o2 <= sat_v[OUT_W];
            end
        end
    end

    tc_rescale_fifo #(
        .W     (OUT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys  (ap_clk),
        .rst_b    (ap_rst_n),
        .wr_en    (v2),
        .wr_data  ({o2, d2}),
        .rd_en    (m_ready),
        .rd_data  (head),
        .rd_valid (m_valid),
        .count    (fifo_cnt)
    );

    assign m_data = head[OUT_W-1:0];
    assign m_ovf  = head[OUT_W];

`ifdef TC_RESCALE_SAT_CNT_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sat_count <= '0;
        end else if (clr_cnt) begin
            sat_count <= '0;
        end else if (v2 && o2 && (sat_count != '1)) begin
            sat_count <= sat_count + 1'b1;
        end
    end
`endif

endmodule
